// File: rtl/asd_pre_pkg.sv
// asd_pre_pkg: source codes, sequencer state codes and request mapping for the source sequencer
package asd_pre_pkg;
  localparam logic [1:0] SRC_ADC     = 2'd0;
  localparam logic [1:0] SRC_TOSLINK = 2'd1;
  localparam logic [1:0] SRC_COAX    = 2'd2;
  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_MUTE_WAIT = 3'd1;
  localparam logic [2:0] ST_SWITCH    = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;
  function automatic logic [1:0] map_source(input logic [1:0] s);
    return s == 2'd0 ? SRC_ADC : s == 2'd1 ? SRC_TOSLINK : SRC_COAX;
  endfunction
endpackage

// File: rtl/source_sequencer.sv
// source_sequencer: sequences audio source changes as mute -> switch -> settle -> unmute
// Ports: bck clock; rst sync active-high reset; req_valid/req_source source-change request;
//   sync frame strobe; lock receiver locked; source mux select; mute zeroes samples;
//   busy high outside RUN; irq pulse on completion or fault entry; fault high in FAULT.
// Build option: SOURCE_SEQ_TIMEOUT_EN adds the SETTLE timeout and makes FAULT reachable.
module source_sequencer
  import asd_pre_pkg::*;
#(
  parameter int MUTE_FRAMES    = 4,
  parameter int SETTLE_FRAMES  = 16,
  parameter int TIMEOUT_FRAMES = 1024
) (
  input  logic       bck,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_source,
  input  logic       sync,
  input  logic       lock,
  output logic [1:0] source,
  output logic       mute,
  output logic       busy,
  output logic       irq,
  output logic       fault
);
  localparam int MW = $clog2(MUTE_FRAMES + 1);
  localparam int LW = $clog2(SETTLE_FRAMES + 1);
  if (MUTE_FRAMES < 1 || SETTLE_FRAMES < 1 || TIMEOUT_FRAMES < 1) begin : g_bad_param
    $error("source_sequencer: frame counts must be at least 1");
  end
  logic [2:0]    r_state, w_state;
  logic [1:0]    r_pending, w_map;
  logic [MW-1:0] r_mcnt, w_mcnt;
  logic [LW-1:0] r_lcnt, w_lcnt;
  logic          w_req, w_wait, w_timeout;
  assign w_map  = map_source(req_source);
  assign w_req  = req_valid && w_map != source;
  assign w_wait = r_state == ST_SETTLE || r_state == ST_FAULT;
  assign w_mcnt = (sync && r_mcnt != MW'(MUTE_FRAMES)) ? r_mcnt + 1'b1 : r_mcnt;
  // a single unlocked cycle restarts the run of consecutive locked frames
  assign w_lcnt = !lock ? '0 : (sync && r_lcnt != LW'(SETTLE_FRAMES)) ? r_lcnt + 1'b1 : r_lcnt;
`ifdef SOURCE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  logic [TW-1:0] r_tcnt, w_tcnt;
  assign w_tcnt    = (sync && r_tcnt != TW'(TIMEOUT_FRAMES)) ? r_tcnt + 1'b1 : r_tcnt;
  assign w_timeout = r_state == ST_SETTLE && w_tcnt == TW'(TIMEOUT_FRAMES);
  always_ff @(posedge bck) begin
    r_tcnt <= (rst || r_state != ST_SETTLE) ? '0 : w_tcnt;
    fault  <= !rst && w_state == ST_FAULT;
  end
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif
  // a new request while already muted skips MUTE_WAIT and goes straight to SWITCH
  always_comb
    w_state = r_state == ST_RUN       ? (w_req ? ST_MUTE_WAIT : ST_RUN) :
              r_state == ST_MUTE_WAIT ? (w_mcnt == MW'(MUTE_FRAMES) ? ST_SWITCH : ST_MUTE_WAIT) :
              r_state == ST_SWITCH    ? ST_SETTLE :
              w_req                   ? ST_SWITCH :
              w_lcnt == LW'(SETTLE_FRAMES) ? ST_RUN :
              w_timeout               ? ST_FAULT :
              w_wait                  ? r_state : ST_SETTLE;
  always_ff @(posedge bck)
    if (rst) begin
      r_state   <= ST_SETTLE;
      source    <= SRC_COAX;
      r_pending <= SRC_COAX;
      r_mcnt    <= '0;
      r_lcnt    <= '0;
      mute      <= 1'b1;
      busy      <= 1'b1;
      irq       <= 1'b0;
    end else begin
      r_state <= w_state;
      if (r_state == ST_MUTE_WAIT ? req_valid : (w_req && r_state != ST_SWITCH)) r_pending <= w_map;
      if (r_state == ST_SWITCH) source <= r_pending;
      r_mcnt <= r_state == ST_MUTE_WAIT ? w_mcnt : '0;
      r_lcnt <= w_wait ? w_lcnt : '0;
      mute   <= w_state != ST_RUN;
      busy   <= w_state != ST_RUN;
      irq    <= (w_state == ST_RUN && r_state != ST_RUN) || (w_state == ST_FAULT && r_state != ST_FAULT);
    end
endmodule

// File: tb/tb_source_sequencer.sv
// tb_source_sequencer: scoreboard bench comparing output changes against a frame-level reference model
module tb_source_sequencer;
  localparam int MF = 4;
  localparam int SF = 16;
  localparam int TF = 1024;
  logic bck = 1'b0;
  logic rst = 1'b1, req_valid = 1'b0, sync = 1'b0, lock = 1'b1;
  logic [1:0] req_source = 2'd0;
  logic [1:0] source;
  logic mute, busy, irq, fault;
  source_sequencer #(.MUTE_FRAMES(MF), .SETTLE_FRAMES(SF), .TIMEOUT_FRAMES(TF)) dut (
    .bck(bck), .rst(rst), .req_valid(req_valid), .req_source(req_source), .sync(sync),
    .lock(lock), .source(source), .mute(mute), .busy(busy), .irq(irq), .fault(fault)
  );
  always #5 bck = ~bck;
  typedef struct {int cyc; logic [5:0] val;} ev_t;
  ev_t exp_q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef enum int {P_RUN, P_MUTING, P_SWITCHING, P_SETTLING, P_FAULT} phase_t;
  phase_t ph = P_SETTLING;
  int src = 2, pend = 2, mframes = 0, lrun = 0, tsync = 0;
  logic m_irq = 1'b0;
  logic [5:0] m_prev = 'x;
  logic [5:0] o_prev = 'x;
  task automatic model_step(input logic r, input logic rv, input logic [1:0] rs, input logic sy, input logic lk);
    int mapped;
    logic [5:0] v;
    mapped = (rs == 2'd3) ? 2 : int'(rs);
    m_irq = 1'b0;
    if (r) begin
      ph = P_SETTLING; src = 2; pend = 2; mframes = 0; lrun = 0; tsync = 0;
    end else begin
      case (ph)
        P_RUN: if (rv && mapped != src) begin ph = P_MUTING; pend = mapped; mframes = 0; end
        P_MUTING: begin
          if (rv) pend = mapped;
          if (sy) mframes++;
          if (mframes >= MF) ph = P_SWITCHING;
        end
        P_SWITCHING: begin src = pend; lrun = 0; tsync = 0; ph = P_SETTLING; end
        default: begin
          lrun = lk ? lrun + int'(sy) : 0;
          if (ph == P_SETTLING && sy) tsync++;
          if (rv && mapped != src) begin pend = mapped; ph = P_SWITCHING; end
          else if (lrun >= SF) begin ph = P_RUN; m_irq = 1'b1; end
`ifdef SOURCE_SEQ_TIMEOUT_EN
          else if (ph == P_SETTLING && tsync >= TF) begin ph = P_FAULT; m_irq = 1'b1; end
`endif
        end
      endcase
    end
    v = {2'(src), ph != P_RUN, ph != P_RUN, m_irq, ph == P_FAULT};
    if (v !== m_prev || m_irq) exp_q.push_back('{cyc, v});
    m_prev = v;
  endtask
  always @(negedge bck) begin
    logic [5:0] obs;
    ev_t e;
    obs = {source, mute, busy, irq, fault};
    if (obs !== o_prev || irq === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL seq_event cyc=%0d actual=%b required=no_change", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== obs) begin
          n_fail++;
          $display("FAIL seq_event actual cyc=%0d src/mute/busy/irq/fault=%b required cyc=%0d %b", cyc, obs, e.cyc, e.val);
        end
      end
      o_prev = obs;
    end
  end
  task automatic step(input logic r, input logic rv, input logic [1:0] rs, input logic sy, input logic lk);
    rst = r; req_valid = rv; req_source = rs; sync = sy; lock = lk;
    @(posedge bck);
    cyc++;
    model_step(r, rv, rs, sy, lk);
    #1;
  endtask
  task automatic frames(input int n, input logic lk, input int gap);
    repeat (n) begin
      step(1'b0, 1'b0, 2'd0, 1'b1, lk);
      repeat (gap - 1) step(1'b0, 1'b0, 2'd0, 1'b0, lk);
    end
  endtask
  task automatic request(input logic [1:0] s);
    step(1'b0, 1'b1, s, 1'b0, 1'b1);
  endtask
  initial begin
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
    frames(SF, 1'b1, 4);
    frames(2, 1'b1, 4);
    request(2'd0);
    frames(MF, 1'b1, 4);
    frames(SF, 1'b1, 4);
    request(2'd1);
    frames(MF, 1'b1, 4);
    frames(10, 1'b1, 4);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    frames(SF, 1'b1, 4);
    request(2'd2);
    frames(MF + SF, 1'b1, 4);
    request(2'd3);
    frames(2, 1'b1, 4);
    request(2'd0);
    frames(2, 1'b1, 4);
    request(2'd1);
    frames(2, 1'b1, 4);
    frames(SF, 1'b1, 4);
    request(2'd0);
    frames(2, 1'b1, 4);
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
    frames(SF + 1, 1'b1, 4);
`ifdef SOURCE_SEQ_TIMEOUT_EN
    request(2'd1);
    frames(MF, 1'b1, 2);
    frames(TF, 1'b0, 2);
    frames(SF, 1'b1, 2);
    frames(2, 1'b1, 2);
`endif
    repeat (4000)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 149) != 0);
    repeat (4) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge bck);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
